// File: rtl/snes_rom_sequencer_if.sv
// Bus bundle between the SNES address decoder / MCU side and the cartridge SRAM sequencer.
// Strobes are one-cycle pulses; mcu_req is a level held until the one-cycle mcu_ack.
interface snes_rom_sequencer_if;
    logic        snes_rd_stb;
    logic        snes_wr_stb;
    logic [23:0] rom_addr;
    logic        rom_hit;
    logic        is_writable;
    logic [7:0]  snes_din;
    logic [7:0]  snes_dout;
    logic        snes_dout_valid;

    logic        mcu_req;
    logic        mcu_we;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata;
    logic        mcu_ack;
    logic [7:0]  mcu_rdata;

    logic [22:0] ram_a;
    logic        ram_bhe_n;
    logic        ram_ble_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [15:0] ram_dout;
    logic        ram_doe;
    logic [15:0] ram_din;

    logic        busy;
    logic [2:0]  state_dbg;

    modport master (
        output snes_rd_stb, snes_wr_stb, rom_addr, rom_hit, is_writable, snes_din,
        output mcu_req, mcu_we, mcu_addr, mcu_wdata, ram_din,
        input  snes_dout, snes_dout_valid, mcu_ack, mcu_rdata,
        input  ram_a, ram_bhe_n, ram_ble_n, ram_oe_n, ram_we_n, ram_dout, ram_doe,
        input  busy, state_dbg
    );

    modport slave (
        input  snes_rd_stb, snes_wr_stb, rom_addr, rom_hit, is_writable, snes_din,
        input  mcu_req, mcu_we, mcu_addr, mcu_wdata, ram_din,
        output snes_dout, snes_dout_valid, mcu_ack, mcu_rdata,
        output ram_a, ram_bhe_n, ram_ble_n, ram_oe_n, ram_we_n, ram_dout, ram_doe,
        output busy, state_dbg
    );
endinterface

// File: rtl/snes_rom_sequencer.sv
// Timed cartridge SRAM sequencer: SNES cycles first, MCU cycles in the gaps, one
// recovery cycle after every access. All RAM-side outputs are registered.
module snes_rom_sequencer #(
    parameter int RD_CYCLES = 5,
    parameter int WR_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    snes_rom_sequencer_if.slave  bus
);
    localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR, RECOVER} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [23:0]   acc_addr, acc_addr_d;
    logic [7:0]    acc_data, acc_data_d;

    logic          snes_pend, pend_wr;
    logic [23:0]   pend_addr;
    logic [7:0]    pend_data;

    logic [22:0]   ram_a_q, ram_a_d;
    logic          bhe_n_q, bhe_n_d, ble_n_q, ble_n_d;
    logic          oe_n_q, oe_n_d, we_n_q, we_n_d, doe_q, doe_d;
    logic [15:0]   dout_q, dout_d;
    logic [7:0]    snes_dout_q, snes_dout_d, mcu_rdata_q, mcu_rdata_d;
    logic          valid_q, valid_d, ack_q, ack_d;

    logic          cap_wr, cap_rd, cap, eff_pend, eff_wr, take_snes;
    logic [23:0]   eff_addr;
    logic [7:0]    eff_data, rd_byte;
    logic          rd_d, wr_d, active_d;

    // A write strobe that qualifies beats a simultaneous read strobe.
    assign cap_wr   = bus.snes_wr_stb && bus.rom_hit && bus.is_writable;
    assign cap_rd   = bus.snes_rd_stb && bus.rom_hit && !cap_wr;
    assign cap      = cap_wr || cap_rd;
    assign eff_pend = cap || snes_pend;
    assign eff_wr   = cap ? cap_wr : pend_wr;
    assign eff_addr = cap ? bus.rom_addr : pend_addr;
    assign eff_data = cap ? bus.snes_din : pend_data;
    // Even byte addresses live on the upper data lane.
    assign rd_byte  = acc_addr[0] ? bus.ram_din[7:0] : bus.ram_din[15:8];

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        acc_addr_d  = acc_addr;
        acc_data_d  = acc_data;
        snes_dout_d = snes_dout_q;
        mcu_rdata_d = mcu_rdata_q;
        valid_d     = 1'b0;
        ack_d       = 1'b0;
        take_snes   = 1'b0;
        case (state)
            IDLE, RECOVER: begin
                state_d = IDLE;
                if (eff_pend) begin
                    take_snes  = 1'b1;
                    state_d    = eff_wr ? SNES_WR : SNES_RD;
                    cnt_d      = eff_wr ? WR_LOAD : RD_LOAD;
                    acc_addr_d = eff_addr;
                    acc_data_d = eff_data;
                end else if (bus.mcu_req) begin
                    state_d    = bus.mcu_we ? MCU_WR : MCU_RD;
                    cnt_d      = bus.mcu_we ? WR_LOAD : RD_LOAD;
                    acc_addr_d = bus.mcu_addr;
                    acc_data_d = bus.mcu_wdata;
                end
            end
            SNES_RD, MCU_RD: begin
                if (cnt == '0) begin
                    state_d = RECOVER;
                    if (state == SNES_RD) begin
                        snes_dout_d = rd_byte;
                        valid_d     = 1'b1;
                    end else begin
                        mcu_rdata_d = rd_byte;
                        ack_d       = 1'b1;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            SNES_WR, MCU_WR: begin
                if (cnt == '0) begin
                    state_d = RECOVER;
                    ack_d   = (state == MCU_WR);
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // RAM pins are decoded from the next state so they change on the entry edge.
        rd_d     = (state_d == SNES_RD) || (state_d == MCU_RD);
        wr_d     = (state_d == SNES_WR) || (state_d == MCU_WR);
        active_d = rd_d || wr_d;
        ram_a_d  = active_d ? acc_addr_d[23:1] : ram_a_q;
        bhe_n_d  = !(active_d && !acc_addr_d[0]);
        ble_n_d  = !(active_d && acc_addr_d[0]);
        oe_n_d   = !rd_d;
        doe_d    = wr_d;
        we_n_d   = !(wr_d && (cnt_d != WR_LOAD) && (cnt_d != '0));
        dout_d   = wr_d ? {acc_data_d, acc_data_d} : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_addr    <= '0;
            acc_data    <= '0;
            snes_pend   <= 1'b0;
            pend_wr     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            ram_a_q     <= '0;
            bhe_n_q     <= 1'b1;
            ble_n_q     <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            doe_q       <= 1'b0;
            dout_q      <= '0;
            snes_dout_q <= '0;
            mcu_rdata_q <= '0;
            valid_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            acc_addr    <= acc_addr_d;
            acc_data    <= acc_data_d;
            ram_a_q     <= ram_a_d;
            bhe_n_q     <= bhe_n_d;
            ble_n_q     <= ble_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            doe_q       <= doe_d;
            dout_q      <= dout_d;
            snes_dout_q <= snes_dout_d;
            mcu_rdata_q <= mcu_rdata_d;
            valid_q     <= valid_d;
            ack_q       <= ack_d;
            // Latest qualifying strobe wins; one captured while a SNES access runs stays pending.
            if (take_snes) begin
                snes_pend <= 1'b0;
            end else if (cap) begin
                snes_pend <= 1'b1;
                pend_wr   <= cap_wr;
                pend_addr <= bus.rom_addr;
                pend_data <= bus.snes_din;
            end
        end
    end

    assign bus.ram_a           = ram_a_q;
    assign bus.ram_bhe_n       = bhe_n_q;
    assign bus.ram_ble_n       = ble_n_q;
    assign bus.ram_oe_n        = oe_n_q;
    assign bus.ram_we_n        = we_n_q;
    assign bus.ram_doe         = doe_q;
    assign bus.ram_dout        = dout_q;
    assign bus.snes_dout       = snes_dout_q;
    assign bus.snes_dout_valid = valid_q;
    assign bus.mcu_rdata       = mcu_rdata_q;
    assign bus.mcu_ack         = ack_q;
    assign bus.busy            = (state != IDLE);
    assign bus.state_dbg       = state;
endmodule
